// File: rtl/usb_host_xact_fsm.sv
// rtl/usb_host_xact_fsm.sv - host-side USB transaction engine with data toggles and retry budget
//
// Ports:
//   clk, rst_b                       clock, asynchronous active-low reset
//   start, dir, addr, endp           request (dir 1=IN, 0=OUT), sampled only when idle
//   data_from_host                   OUT payload, latched on an accepted start
//   toggle_clr                       clear every DATA0/DATA1 toggle
//   pkt_sent                         encoder finished the current packet
//   pkt_received, crc_correct        decoder delivered a packet / its CRC verdict
//   pkt_in_pid, pkt_in_data          received packet contents
//   encode, kill                     one-cycle pulse: start encoding pkt_out_*
//   decode                           one-cycle pulse: arm the decoder
//   pkt_out_pid/addr/endp/data       packet to encode, held until the next encode
//   data_to_host                     last good IN payload
//   busy, done, status               progress and completion (00 OK, 01 retries, 10 stall, 11 bad ep)
module usb_host_xact_fsm #(
  parameter int DATA_W         = 64,
  parameter int NUM_EP         = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 8
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              dir,
  input  logic [6:0]        addr,
  input  logic [3:0]        endp,
  input  logic [DATA_W-1:0] data_from_host,
  input  logic              toggle_clr,
  input  logic              pkt_sent,
  input  logic              pkt_received,
  input  logic              crc_correct,
  input  logic [3:0]        pkt_in_pid,
  input  logic [DATA_W-1:0] pkt_in_data,
  output logic              encode,
  output logic              kill,
  output logic              decode,
  output logic [3:0]        pkt_out_pid,
  output logic [6:0]        pkt_out_addr,
  output logic [3:0]        pkt_out_endp,
  output logic [DATA_W-1:0] pkt_out_data,
  output logic [DATA_W-1:0] data_to_host,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_EXHAUSTED = 2'b01;
  localparam logic [1:0] ST_STALL     = 2'b10;
  localparam logic [1:0] ST_BAD_EP    = 2'b11;

  localparam int LCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ECW = $clog2(MAX_RETRIES + 1);
  localparam logic [LCW-1:0] LISTEN_LAST = LCW'(TIMEOUT_CYCLES - 1);
  localparam logic [ECW-1:0] ERR_LAST    = ECW'(MAX_RETRIES - 1);
  localparam logic [4:0]     NUM_EP_L    = 5'(NUM_EP);

  typedef enum logic [2:0] {IDLE, TOK_WAIT, DATA_WAIT, OUT_LISTEN, IN_LISTEN, HS_WAIT} state_t;
  // What to do once the handshake we are sending has left the encoder.
  typedef enum logic [1:0] {HS_EXIT_OK, HS_EXIT_RETOKEN, HS_EXIT_RELISTEN} hs_exit_t;

  state_t            state;
  hs_exit_t          hs_exit;
  logic              dir_q;
  logic [6:0]        addr_q;
  logic [3:0]        endp_q;
  logic [DATA_W-1:0] data_q;
  logic [ECW-1:0]    err_cnt;
  logic [LCW-1:0]    listen_cnt;
  // Indexed directly by the 4-bit endpoint; entries at or above NUM_EP are never flipped.
  logic [15:0]       tog_in;
  logic [15:0]       tog_out;

  logic       ep_bad, err_last, timeout, cur_tog_in, cur_tog_out, rx_good, rx_is_data;
  logic [3:0] data_pid_out;

  assign ep_bad       = {1'b0, endp} >= NUM_EP_L;
  assign err_last     = (err_cnt == ERR_LAST);
  assign timeout      = (listen_cnt == LISTEN_LAST);
  assign cur_tog_in   = tog_in[endp_q];
  assign cur_tog_out  = tog_out[endp_q];
  assign rx_good      = pkt_received && crc_correct;
  assign rx_is_data   = rx_good && ((pkt_in_pid == PID_DATA0) || (pkt_in_pid == PID_DATA1));
  assign data_pid_out = cur_tog_out ? PID_DATA1 : PID_DATA0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      hs_exit      <= HS_EXIT_OK;
      dir_q        <= 1'b0;
      addr_q       <= '0;
      endp_q       <= '0;
      data_q       <= '0;
      err_cnt      <= '0;
      listen_cnt   <= '0;
      tog_in       <= '0;
      tog_out      <= '0;
      encode       <= 1'b0;
      kill         <= 1'b0;
      decode       <= 1'b0;
      pkt_out_pid  <= '0;
      pkt_out_addr <= '0;
      pkt_out_endp <= '0;
      pkt_out_data <= '0;
      data_to_host <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      status       <= ST_OK;
    end else begin
      encode <= 1'b0;
      kill   <= 1'b0;
      decode <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          // busy lingers through the done cycle, so a start there is ignored.
          busy <= 1'b0;
          if (start && !busy) begin
            if (ep_bad) begin
              done   <= 1'b1;
              status <= ST_BAD_EP;
            end else begin
              busy         <= 1'b1;
              dir_q        <= dir;
              addr_q       <= addr;
              endp_q       <= endp;
              data_q       <= data_from_host;
              err_cnt      <= '0;
              encode       <= 1'b1;
              kill         <= 1'b1;
              pkt_out_pid  <= dir ? PID_IN : PID_OUT;
              pkt_out_addr <= addr;
              pkt_out_endp <= endp;
              pkt_out_data <= '0;
              state        <= TOK_WAIT;
            end
          end
        end
        TOK_WAIT: begin
          if (pkt_sent) begin
            if (dir_q) begin
              decode     <= 1'b1;
              listen_cnt <= '0;
              state      <= IN_LISTEN;
            end else begin
              encode       <= 1'b1;
              kill         <= 1'b1;
              pkt_out_pid  <= data_pid_out;
              pkt_out_data <= data_q;
              state        <= DATA_WAIT;
            end
          end
        end
        DATA_WAIT: begin
          if (pkt_sent) begin
            decode     <= 1'b1;
            listen_cnt <= '0;
            state      <= OUT_LISTEN;
          end
        end
        OUT_LISTEN: begin
          listen_cnt <= listen_cnt + 1'b1;
          if (rx_good && pkt_in_pid == PID_ACK) begin
            tog_out[endp_q] <= ~cur_tog_out;
            done            <= 1'b1;
            status          <= ST_OK;
            state           <= IDLE;
          end else if (rx_good && pkt_in_pid == PID_STALL) begin
            done   <= 1'b1;
            status <= ST_STALL;
            state  <= IDLE;
          end else if (pkt_received || timeout) begin
            if (err_last) begin
              done   <= 1'b1;
              status <= ST_EXHAUSTED;
              state  <= IDLE;
            end else begin
              // Resend the same DATAx: the toggle only advances on ACK.
              err_cnt      <= err_cnt + 1'b1;
              encode       <= 1'b1;
              kill         <= 1'b1;
              pkt_out_pid  <= data_pid_out;
              pkt_out_data <= data_q;
              state        <= DATA_WAIT;
            end
          end
        end
        IN_LISTEN: begin
          listen_cnt <= listen_cnt + 1'b1;
          if (rx_is_data && (pkt_in_pid[3] == cur_tog_in)) begin
            data_to_host   <= pkt_in_data;
            tog_in[endp_q] <= ~cur_tog_in;
            encode         <= 1'b1;
            kill           <= 1'b1;
            pkt_out_pid    <= PID_ACK;
            pkt_out_data   <= '0;
            hs_exit        <= HS_EXIT_OK;
            state          <= HS_WAIT;
          end else if (rx_good && pkt_in_pid == PID_STALL) begin
            done   <= 1'b1;
            status <= ST_STALL;
            state  <= IDLE;
          end else if (pkt_received || timeout) begin
            if (err_last) begin
              done   <= 1'b1;
              status <= ST_EXHAUSTED;
              state  <= IDLE;
            end else begin
              err_cnt <= err_cnt + 1'b1;
              if (pkt_received && !crc_correct) begin
                encode       <= 1'b1;
                kill         <= 1'b1;
                pkt_out_pid  <= PID_NAK;
                pkt_out_data <= '0;
                hs_exit      <= HS_EXIT_RELISTEN;
                state        <= HS_WAIT;
              end else if (rx_is_data) begin
                // Duplicate of a packet we already took: ACK it so the device advances.
                encode       <= 1'b1;
                kill         <= 1'b1;
                pkt_out_pid  <= PID_ACK;
                pkt_out_data <= '0;
                hs_exit      <= HS_EXIT_RETOKEN;
                state        <= HS_WAIT;
              end else begin
                encode       <= 1'b1;
                kill         <= 1'b1;
                pkt_out_pid  <= PID_IN;
                pkt_out_data <= '0;
                state        <= TOK_WAIT;
              end
            end
          end
        end
        HS_WAIT: begin
          if (pkt_sent) begin
            case (hs_exit)
              HS_EXIT_OK: begin
                done   <= 1'b1;
                status <= ST_OK;
                state  <= IDLE;
              end
              HS_EXIT_RETOKEN: begin
                encode       <= 1'b1;
                kill         <= 1'b1;
                pkt_out_pid  <= PID_IN;
                pkt_out_data <= '0;
                state        <= TOK_WAIT;
              end
              default: begin
                decode     <= 1'b1;
                listen_cnt <= '0;
                state      <= IN_LISTEN;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
      // Clearing takes priority over any flip scheduled above.
      if (toggle_clr) begin
        tog_in  <= '0;
        tog_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_usb_host_xact_fsm.sv
// tb/tb_usb_host_xact_fsm.sv - self-checking bench for usb_host_xact_fsm
module tb_usb_host_xact_fsm;
  localparam int DATA_W = 64;
  localparam int NUM_EP = 12;
  localparam int TMO    = 255;
  localparam int MAXR   = 8;
  localparam int BUDGET = 4000;

  localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_D0 = 4'b0011, P_D1 = 4'b1011;
  localparam logic [3:0] P_ACK = 4'b0010, P_NAK = 4'b1010, P_STALL = 4'b1110;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0, dir = 1'b0, toggle_clr = 1'b0;
  logic [6:0] addr = '0;
  logic [3:0] endp = '0;
  logic [DATA_W-1:0] data_from_host = '0;
  logic pkt_sent = 1'b0, pkt_received = 1'b0, crc_correct = 1'b0;
  logic [3:0] pkt_in_pid = '0;
  logic [DATA_W-1:0] pkt_in_data = '0;
  logic encode, kill, decode, busy, done;
  logic [3:0] pkt_out_pid, pkt_out_endp;
  logic [6:0] pkt_out_addr;
  logic [DATA_W-1:0] pkt_out_data, data_to_host;
  logic [1:0] status;

  usb_host_xact_fsm #(.DATA_W(DATA_W), .NUM_EP(NUM_EP), .TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .dir(dir), .addr(addr), .endp(endp),
    .data_from_host(data_from_host), .toggle_clr(toggle_clr), .pkt_sent(pkt_sent),
    .pkt_received(pkt_received), .crc_correct(crc_correct), .pkt_in_pid(pkt_in_pid),
    .pkt_in_data(pkt_in_data), .encode(encode), .kill(kill), .decode(decode),
    .pkt_out_pid(pkt_out_pid), .pkt_out_addr(pkt_out_addr), .pkt_out_endp(pkt_out_endp),
    .pkt_out_data(pkt_out_data), .data_to_host(data_to_host), .busy(busy), .done(done),
    .status(status));

  always #5 clk = ~clk;

  typedef struct { bit none; bit crc; logic [3:0] pid; logic [63:0] data; } resp_t;
  typedef struct { logic [3:0] pid; logic [6:0] addr; logic [3:0] endp; logic [63:0] data; int cyc; } pkt_t;

  int checks = 0, errors = 0;
  resp_t script[$];
  pkt_t obs[$], exp_q[$];
  int dec_cyc[$];
  int dones, got_status, done_cyc, kill_bad, exp_status;
  logic busy_at_done, busy_after;
  bit m_tog_in[16], m_tog_out[16];
  logic [63:0] m_dth = '0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic resp_t rp(bit none, bit crc, logic [3:0] pid, logic [63:0] data);
    resp_t r;
    r.none = none; r.crc = crc; r.pid = pid; r.data = data;
    return r;
  endfunction

  function automatic pkt_t mk(logic [3:0] p, logic [6:0] a, logic [3:0] e, logic [63:0] d);
    pkt_t r;
    r.pid = p; r.addr = a; r.endp = e; r.data = d; r.cyc = 0;
    return r;
  endfunction

  function automatic bit is_data(logic [3:0] p);
    return (p == P_D0) || (p == P_D1);
  endfunction

  // Transaction-level reference: walk the device's answers one listen at a time.
  function automatic void model_xact(bit d, logic [6:0] a, logic [3:0] e, logic [63:0] dat, bit clr);
    int errs = 0;
    int ri = 0;
    bit fin = 0;
    resp_t r;
    exp_q.delete();
    if (int'(e) >= NUM_EP) begin
      exp_status = 3;
      return;
    end
    exp_q.push_back(mk(d ? P_IN : P_OUT, a, e, 64'd0));
    while (!fin) begin
      if (!d) exp_q.push_back(mk(m_tog_out[e] ? P_D1 : P_D0, a, e, dat));
      r = (ri < script.size()) ? script[ri] : rp(1, 0, 4'd0, 64'd0);
      ri++;
      if (!r.none && r.crc && !d && r.pid == P_ACK) begin
        m_tog_out[e] = !m_tog_out[e]; exp_status = 0; fin = 1;
      end else if (!r.none && r.crc && r.pid == P_STALL) begin
        exp_status = 2; fin = 1;
      end else if (d && !r.none && r.crc && is_data(r.pid) && (r.pid[3] == m_tog_in[e])) begin
        m_dth = r.data; m_tog_in[e] = !m_tog_in[e];
        exp_q.push_back(mk(P_ACK, a, e, 64'd0));
        exp_status = 0; fin = 1;
      end else if (errs == MAXR - 1) begin
        exp_status = 1; fin = 1;
      end else begin
        errs++;
        if (d) begin
          if (!r.none && !r.crc) exp_q.push_back(mk(P_NAK, a, e, 64'd0));
          else begin
            if (!r.none && is_data(r.pid)) exp_q.push_back(mk(P_ACK, a, e, 64'd0));
            exp_q.push_back(mk(P_IN, a, e, 64'd0));
          end
        end
      end
    end
    if (clr) for (int i = 0; i < 16; i++) begin m_tog_in[i] = 0; m_tog_out[i] = 0; end
  endfunction

  // Acts as host command layer plus encoder/decoder/device. Called at a negedge.
  task automatic drive_xact(input bit d, input logic [6:0] a, input logic [3:0] e,
                            input logic [63:0] dat, input bit clr);
    int cyc = 1, sent_cd = -1, rcv_cd = -1, ri = 0;
    bit fin = 0;
    resp_t cur = rp(1, 0, 4'd0, 64'd0);
    obs.delete(); dec_cyc.delete();
    dones = 0; got_status = -1; done_cyc = -1; kill_bad = 0; busy_at_done = 1'bx;
    start = 1; dir = d; addr = a; endp = e; data_from_host = dat;
    @(negedge clk);
    start = 0; dir = 1'($urandom); addr = 7'($urandom); endp = 4'($urandom);
    data_from_host = {$urandom, $urandom};
    while (!fin && cyc < BUDGET) begin
      pkt_sent = 0; pkt_received = 0; toggle_clr = 0;
      crc_correct = 1'($urandom); pkt_in_pid = 4'($urandom); pkt_in_data = {$urandom, $urandom};
      if (kill !== encode) kill_bad++;
      if (encode) begin
        obs.push_back('{pkt_out_pid, pkt_out_addr, pkt_out_endp, pkt_out_data, cyc});
        sent_cd = $urandom_range(0, 3);
      end
      if (decode) begin
        dec_cyc.push_back(cyc);
        cur = (ri < script.size()) ? script[ri] : rp(1, 0, 4'd0, 64'd0);
        ri++;
        rcv_cd = cur.none ? -1 : $urandom_range(0, 8);
      end
      if (done) begin
        dones++; got_status = status; done_cyc = cyc; busy_at_done = busy; fin = 1;
      end else begin
        if (sent_cd == 0) begin pkt_sent = 1; sent_cd = -1; end
        else if (sent_cd > 0) sent_cd--;
        if (rcv_cd == 0) begin
          pkt_received = 1; crc_correct = cur.crc; pkt_in_pid = cur.pid; pkt_in_data = cur.data;
          toggle_clr = clr; rcv_cd = -1;
        end else if (rcv_cd > 0) rcv_cd--;
      end
      @(negedge clk);
      cyc++;
    end
    pkt_sent = 0; pkt_received = 0; toggle_clr = 0;
    busy_after = busy;
    for (int k = 0; k < 4; k++) begin
      if (encode) obs.push_back('{pkt_out_pid, pkt_out_addr, pkt_out_endp, pkt_out_data, cyc});
      if (done) dones++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic compare_xact(input string tag);
    chk({tag, ":done_count"}, dones, 1);
    chk({tag, ":status"}, got_status, exp_status);
    chk({tag, ":num_pkts"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s:pid%0d", tag, i), obs[i].pid, exp_q[i].pid);
      if (exp_q[i].pid == P_IN || exp_q[i].pid == P_OUT) begin
        chk($sformatf("%s:addr%0d", tag, i), obs[i].addr, exp_q[i].addr);
        chk($sformatf("%s:endp%0d", tag, i), obs[i].endp, exp_q[i].endp);
      end
      if (is_data(exp_q[i].pid)) chk($sformatf("%s:data%0d", tag, i), obs[i].data, exp_q[i].data);
    end
    chk({tag, ":data_to_host"}, data_to_host, m_dth);
    chk({tag, ":busy_at_done"}, busy_at_done, exp_status != 3);
    chk({tag, ":busy_after"}, busy_after, 1'b0);
    chk({tag, ":kill_eq_encode"}, kill_bad, 0);
  endtask

  task automatic run(input string tag, input bit d, input logic [6:0] a, input logic [3:0] e,
                     input logic [63:0] dat, input bit clr);
    model_xact(d, a, e, dat, clr);
    drive_xact(d, a, e, dat, clr);
    compare_xact(tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":ctl"}, {encode, kill, decode, busy, done, status, pkt_out_pid, pkt_out_addr, pkt_out_endp}, '0);
    chk({tag, ":pkt_out_data"}, pkt_out_data, '0);
    chk({tag, ":data_to_host"}, data_to_host, '0);
  endtask

  function automatic resp_t rand_resp();
    resp_t r;
    int k = $urandom_range(0, 9);
    int p = $urandom_range(0, 9);
    r.none = (k == 0);
    r.crc = !(k == 1 || k == 2);
    r.data = {$urandom, $urandom};
    case (p)
      0, 1:    r.pid = P_ACK;
      2:       r.pid = P_NAK;
      3:       r.pid = P_STALL;
      4, 5:    r.pid = P_D0;
      6, 7:    r.pid = P_D1;
      default: r.pid = 4'($urandom);
    endcase
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit rd;
    logic [3:0] re;
    for (int i = 0; i < 16; i++) begin m_tog_in[i] = 0; m_tog_out[i] = 0; end

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_b = 1;
    @(negedge clk);

    script.delete(); script.push_back(rp(0, 1, P_ACK, 64'd0));
    run("out_ack", 0, 7'd5, 4'd4, 64'h0123456789ABCDEF, 0);
    if (obs.size() > 0) chk("out_ack:token_at_n_plus_1", obs[0].cyc, 1);
    run("out_ack_2nd", 0, 7'd5, 4'd4, 64'h1122334455667788, 0);

    script.delete(); script.push_back(rp(0, 1, P_D0, 64'hCAFE));
    run("in_data0", 1, 7'd9, 4'd2, 64'd0, 0);

    script.delete();
    script.push_back(rp(0, 0, P_D0, 64'hDEAD));
    script.push_back(rp(0, 0, P_D0, 64'hBEEF));
    script.push_back(rp(0, 1, P_D0, 64'h5A5A));
    run("in_badcrc_x2", 1, 7'd9, 4'd3, 64'd0, 0);

    script.delete();
    run("out_timeouts", 0, 7'd17, 4'd6, 64'hF0F0, 0);
    for (int k = 2; k < obs.size(); k++)
      if (k - 2 < dec_cyc.size()) chk($sformatf("out_timeouts:gap%0d", k), obs[k].cyc - dec_cyc[k-2], TMO);
    if (dec_cyc.size() > 0) chk("out_timeouts:gap_done", done_cyc - dec_cyc[dec_cyc.size()-1], TMO);

    script.delete(); script.push_back(rp(0, 1, P_STALL, 64'd0));
    run("in_stall", 1, 7'd2, 4'd1, 64'd0, 0);

    script.delete();
    run("bad_ep", 0, 7'd2, 4'(NUM_EP), 64'd0, 0);
    chk("bad_ep:done_at_n_plus_1", done_cyc, 1);

    script.delete(); script.push_back(rp(0, 1, P_ACK, 64'd0));
    run("out_clr", 0, 7'd8, 4'd7, 64'h77, 1);
    run("out_after_clr", 0, 7'd8, 4'd7, 64'h78, 0);
    script.delete(); script.push_back(rp(0, 1, P_D0, 64'h99));
    run("in_clr", 1, 7'd8, 4'd5, 64'd0, 1);
    script.delete(); script.push_back(rp(0, 1, P_D0, 64'h9A));
    run("in_after_clr", 1, 7'd8, 4'd5, 64'd0, 0);

    // Reset asserted while the engine is listening for an OUT handshake.
    start = 1; dir = 0; addr = 7'd3; endp = 4'd9; data_from_host = 64'h1234;
    @(negedge clk);
    start = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      pkt_sent = encode;
      if (decode) seen = 1;
      @(negedge clk);
    end
    pkt_sent = 0;
    chk("midrst:reached_listen", seen, 1);
    repeat (3) @(negedge clk);
    #2 rst_b = 0;
    #1 chk_reset_outputs("midrst_async");
    @(negedge clk);
    rst_b = 1;
    for (int i = 0; i < 16; i++) begin m_tog_in[i] = 0; m_tog_out[i] = 0; end
    m_dth = '0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    chk("midrst:no_done", dones, 0);
    chk_reset_outputs("midrst_after");
    script.delete(); script.push_back(rp(0, 1, P_ACK, 64'd0));
    run("out_after_rst", 0, 7'd5, 4'd4, 64'hABCD, 0);

    for (int t = 0; t < 30; t++) begin
      rd = 1'($urandom);
      re = 4'($urandom_range(0, NUM_EP + 1));
      script.delete();
      for (int j = 0; j < MAXR; j++) script.push_back(rand_resp());
      run($sformatf("rand%0d", t), rd, 7'($urandom), re, {$urandom, $urandom}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
